// File: rtl/tiny_dnn_pkg.sv
// Shared types and arithmetic for the fixed-point MAC array.
// sat_add works on a wide carrier so any accumulator width up to SAT_W-1 can share it.
package tiny_dnn_pkg;

    localparam int DW_DEF    = 16;
    localparam int WW_DEF    = 16;
    localparam int ACC_W_DEF = 40;
    localparam int SAT_W     = 64;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    // a and b are sign-extended w-bit values; result is clamped to the signed w-bit range
    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int                      w
    );
        logic signed [SAT_W:0] s, hi, lo, one;
        one = {{SAT_W{1'b0}}, 1'b1};
        s   = {a[SAT_W-1], a} + {b[SAT_W-1], b};
        hi  = (one <<< (w - 1)) - one;
        lo  = ~hi;
        if (s > hi)      sat_add = hi[SAT_W-1:0];
        else if (s < lo) sat_add = lo[SAT_W-1:0];
        else             sat_add = s[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/tiny_dnn_mac_lane.sv
// One output channel: private weight RAM, two-stage multiply/accumulate, saturation and ReLU.
// Weight RAM and the stage-1 operand registers are deliberately left without reset.
module tiny_dnn_mac_lane
    import tiny_dnn_pkg::*;
#(
    parameter  int F_SIZE = 512,
    parameter  int DW     = DW_DEF,
    parameter  int WW     = WW_DEF,
    parameter  int ACC_W  = ACC_W_DEF,
    localparam int AW     = $clog2(F_SIZE)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_we,
    input  logic [AW-1:0]           i_waddr,
    input  logic signed [WW-1:0]    i_wdata,
    input  logic                    i_beat,
    input  logic [AW-1:0]           i_raddr,
    input  logic signed [DW-1:0]    i_d,
    input  logic                    i_clr,
    input  logic                    i_relu,
    output logic signed [ACC_W-1:0] o_acc
);

    logic signed [WW-1:0]    r_mem [F_SIZE];
    logic signed [WW-1:0]    r_w;
    logic signed [DW-1:0]    r_d;
    logic                    r_v1;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [DW+WW-1:0] w_prod;

    assign w_prod = r_d * r_w;
    assign o_acc  = r_acc;

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
        if (i_beat) begin
            r_w <= r_mem[i_raddr];
            r_d <= i_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1  <= 1'b0;
            r_acc <= '0;
        end else begin
            r_v1 <= i_beat;
            if (i_clr)
                r_acc <= '0;
            else if (r_v1)
                r_acc <= ACC_W'(sat_add(SAT_W'(r_acc), SAT_W'(w_prod), ACC_W));
            else if (i_relu && r_acc[ACC_W-1])
                r_acc <= '0;
        end
    end

endmodule

// File: rtl/tiny_dnn_mac_array.sv
// F_NUM parallel MAC lanes fed by one streamed input vector; owns the run sequencer,
// weight-write decode and the registered result mux.
module tiny_dnn_mac_array
    import tiny_dnn_pkg::*;
#(
    parameter  int F_NUM  = 16,
    parameter  int F_SIZE = 512,
    parameter  int DW     = DW_DEF,
    parameter  int WW     = WW_DEF,
    parameter  int ACC_W  = ACC_W_DEF,
    localparam int AW     = $clog2(F_SIZE),
    localparam int CW     = $clog2(F_NUM)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [CW+AW-1:0]        wr_addr,
    input  logic signed [WW-1:0]    wr_data,
    input  logic                    start,
    input  logic [AW:0]             len,
    input  logic                    relu,
    input  logic                    d_valid,
    output logic                    d_ready,
    input  logic signed [DW-1:0]    d_data,
    output logic                    busy,
    output logic                    done,
    input  logic [CW-1:0]           rd_addr,
    output logic signed [ACC_W-1:0] rd_data
);

    state_t                  r_state, w_nxt;
    logic [AW-1:0]           r_cnt;
    logic [AW:0]             r_len;
    logic                    r_relu;
    logic                    r_done;
    logic [1:0]              r_vld_pipe;
    logic                    w_beat, w_last, w_clr, w_relu, w_wr_ok;
    logic signed [ACC_W-1:0] w_acc [F_NUM];
    logic signed [ACC_W-1:0] w_rd_sel;

    assign d_ready = (r_state == RUN);
    assign busy    = (r_state != IDLE);
    assign done    = r_done;
    assign w_beat  = d_valid && d_ready;
    assign w_last  = ({1'b0, r_cnt} == (r_len - (AW+1)'(1)));
    assign w_clr   = (r_state == IDLE) && start;
    assign w_relu  = (r_state == FIN) && r_relu;
    assign w_wr_ok = wr_en && (r_state == IDLE);

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_nxt = (len == '0) ? FIN : RUN;
            RUN:     if (w_beat && w_last) w_nxt = DRAIN;
            // stage 2 has retired and nothing is behind it
            DRAIN:   if (r_vld_pipe == 2'b10) w_nxt = FIN;
            FIN:     w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_len      <= '0;
            r_relu     <= 1'b0;
            r_done     <= 1'b0;
            r_vld_pipe <= '0;
            rd_data    <= '0;
        end else begin
            r_state    <= w_nxt;
            r_done     <= (r_state == FIN);
            r_vld_pipe <= {r_vld_pipe[0], w_beat};
            rd_data    <= w_rd_sel;
            if (w_clr) begin
                r_len  <= len;
                r_relu <= relu;
                r_cnt  <= '0;
            end else if (w_beat) begin
                r_cnt  <= r_cnt + AW'(1);
            end
        end
    end

    // Unmatched channel codes select nothing, so out-of-range reads return 0
    always_comb begin
        w_rd_sel = '0;
        for (int i = 0; i < F_NUM; i++)
            if (rd_addr == CW'(i)) w_rd_sel = w_acc[i];
    end

    for (genvar g = 0; g < F_NUM; g++) begin : g_lane
        tiny_dnn_mac_lane #(
            .F_SIZE (F_SIZE),
            .DW     (DW),
            .WW     (WW),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .i_we    (w_wr_ok && (wr_addr[CW+AW-1:AW] == CW'(g))),
            .i_waddr (wr_addr[AW-1:0]),
            .i_wdata (wr_data),
            .i_beat  (w_beat),
            .i_raddr (r_cnt),
            .i_d     (d_data),
            .i_clr   (w_clr),
            .i_relu  (w_relu),
            .o_acc   (w_acc[g])
        );
    end

endmodule

// File: tb/tb_tiny_dnn_mac_array.sv
// Directed bench for tiny_dnn_mac_array: three lanes (so channel code 3 is out of range),
// 32-bit accumulators so saturation is reachable within one 512-element run.
module tb_tiny_dnn_mac_array;

    localparam int F_NUM  = 3;
    localparam int F_SIZE = 512;
    localparam int DW     = 16;
    localparam int WW     = 16;
    localparam int ACC_W  = 32;
    localparam int AW     = 9;
    localparam int CW     = 2;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    wr_en = 1'b0;
    logic [CW+AW-1:0]        wr_addr = '0;
    logic signed [WW-1:0]    wr_data = '0;
    logic                    start = 1'b0;
    logic [AW:0]             len = '0;
    logic                    relu = 1'b0;
    logic                    d_valid = 1'b0;
    logic                    d_ready;
    logic signed [DW-1:0]    d_data = '0;
    logic                    busy;
    logic                    done;
    logic [CW-1:0]           rd_addr = '0;
    logic signed [ACC_W-1:0] rd_data;

    int n_cmp = 0;
    int n_err = 0;
    logic signed [15:0] vec [F_SIZE];
    logic [31:0]        rv;

    tiny_dnn_mac_array #(
        .F_NUM(F_NUM), .F_SIZE(F_SIZE), .DW(DW), .WW(WW), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .len(len), .relu(relu), .d_valid(d_valid), .d_ready(d_ready),
        .d_data(d_data), .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr_w(input int ch, input int idx, input int val);
        wr_en   = 1'b1;
        wr_addr = {CW'(ch), AW'(idx)};
        wr_data = WW'(val);
        @(posedge clk); #1;
        wr_en   = 1'b0;
    endtask

    task automatic rd(input int ch, output logic [31:0] r);
        rd_addr = CW'(ch);
        @(posedge clk); #1;
        r = rd_data;
    endtask

    // Streams vec[0..n-1]; gap inserts an idle cycle before each beat, inj drives a
    // weight write plus a start pulse alongside beat 1. Checks done timing afterwards.
    task automatic run(input int n, input bit rl, input bit gap, input bit inj);
        int t;
        start = 1'b1; len = (AW+1)'(n); relu = rl;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        for (int k = 0; k < n; k++) begin
            if (gap) begin
                d_valid = 1'b0;
                @(posedge clk); #1;
            end
            d_valid = 1'b1;
            d_data  = vec[k];
            if (inj && k == 1) begin
                wr_en = 1'b1; wr_addr = '0; wr_data = 16'sd99;
                start = 1'b1; len = (AW+1)'(1);
            end
            t = 0;
            while (!d_ready && t < 50) begin
                @(posedge clk); #1; t++;
            end
            check("d_ready_beat", d_ready, 1);
            @(posedge clk); #1;
            wr_en = 1'b0; start = 1'b0;
        end
        d_valid = 1'b0;
        @(posedge clk); #1; check("done_e1", done, 0);
        @(posedge clk); #1; check("done_e2", done, 0); check("busy_fin", busy, 1);
        @(posedge clk); #1; check("done_e3", done, 1); check("busy_idle", busy, 0);
        @(posedge clk); #1; check("done_e4", done, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", d_ready, 0);
        check("rst_rd", rd_data, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        rd(0, rv); check("rst_acc0", rv, 0);

        for (int i = 0; i < 4; i++) begin
            wr_w(0, i, i + 1);
            wr_w(1, i, -1);
        end
        vec[0] = 16'sd10; vec[1] = 16'sd20; vec[2] = 16'sd30; vec[3] = 16'sd40;

        // plain run: 10+40+90+160 and -(10+20+30+40)
        run(4, 1'b0, 1'b0, 1'b0);
        rd(0, rv); check("run1_ch0", rv, 32'd300);
        rd(1, rv); check("run1_ch1", rv, 32'hFFFF_FF9C);
        rd(3, rv); check("rd_oob", rv, 0);

        // ReLU with bubbles
        run(4, 1'b1, 1'b1, 1'b0);
        rd(0, rv); check("relu_ch0", rv, 32'd300);
        rd(1, rv); check("relu_ch1", rv, 0);

        // zero-length run
        start = 1'b1; len = '0; relu = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        check("len0_ready", d_ready, 0);
        check("len0_busy", busy, 1);
        check("len0_done_early", done, 0);
        @(posedge clk); #1;
        check("len0_done", done, 1);
        check("len0_idle", busy, 0);
        rd(0, rv); check("len0_ch0", rv, 0);
        rd(1, rv); check("len0_ch1", rv, 0);

        // write and start during a run are dropped
        run(4, 1'b0, 1'b0, 1'b1);
        rd(0, rv); check("inj_ch0", rv, 32'd300);
        vec[0] = 16'sd1;
        run(1, 1'b0, 1'b0, 1'b0);
        rd(0, rv); check("inj_oldw", rv, 32'd1);
        rd(1, rv); check("inj_ch1", rv, 32'hFFFF_FFFF);

        // out-of-range channel write must not land in any lane
        wr_w(3, 0, 500);
        run(1, 1'b0, 1'b0, 1'b0);
        rd(0, rv); check("oob_wr_ch0", rv, 32'd1);

        // saturation, positive then negative
        for (int i = 0; i < F_SIZE; i++) wr_w(2, i, 32'h7FFF);
        for (int i = 0; i < F_SIZE; i++) vec[i] = 16'sh7FFF;
        run(512, 1'b0, 1'b0, 1'b0);
        rd(2, rv); check("sat_pos", rv, 32'h7FFF_FFFF);
        for (int i = 0; i < F_SIZE; i++) vec[i] = -16'sh8000;
        run(512, 1'b0, 1'b0, 1'b0);
        rd(2, rv); check("sat_neg", rv, 32'h8000_0000);

        // reset in the middle of a run
        vec[0] = 16'sd10; vec[1] = 16'sd20; vec[2] = 16'sd30; vec[3] = 16'sd40;
        start = 1'b1; len = (AW+1)'(8); relu = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        d_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            d_data = vec[k];
            @(posedge clk); #1;
        end
        check("mid_busy_pre", busy, 1);
        reset = 1'b1;
        #1;
        check("mid_busy", busy, 0);
        check("mid_ready", d_ready, 0);
        check("mid_done", done, 0);
        d_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        rd(0, rv); check("mid_acc0", rv, 0);
        rd(1, rv); check("mid_acc1", rv, 0);
        run(4, 1'b0, 1'b0, 1'b0);
        rd(0, rv); check("post_rst_ch0", rv, 32'd300);
        rd(1, rv); check("post_rst_ch1", rv, 32'hFFFF_FF9C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
